aud_clk_sched: RTL and testbench

//  Audio clock scheduler for the four-channel frequency counters. Holds AUDCTL, derives
//  the 64 kHz / 15 kHz base strobe (audClock) from the machine-cycle enable, drives the

---
 rtl/aud_clk_sched.sv | 95 +++++++++
 tb/tb_aud_clk_sched.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/aud_clk_sched.sv
// Audio clock scheduler: AUDCTL/SKCTL holding, 64 kHz / 15 kHz base strobe generation
// and STIMER re-phasing of the two free-running prescalers.
module aud_clk_sched #(
    parameter int DIV64K = 28,
    parameter int DIV15K = 114,
    parameter int CW     = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enp,
    input  logic [7:0] D,
    input  logic       Addr8w,
    input  logic       Addr9w,
    input  logic       Addr15w,
    output logic       audClock,
    output logic       enFastClk1,
    output logic       enFastClk3,
    output logic       ch2Bits16,
    output logic       ch4Bits16,
    output logic       hpf1,
    output logic       hpf2,
    output logic       poly9,
    output logic       sel15k,
    output logic       initMode
);

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_SYNC} state_t;

    localparam logic [CW-1:0] TC64 = CW'(DIV64K - 1);
    localparam logic [CW-1:0] TC15 = CW'(DIV15K - 1);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    audctl;
    logic [1:0]    skctl;
    logic [CW-1:0] cnt64;
    logic [CW-1:0] cnt15;
    logic          go_init;
    logic          hold_zero;
    logic          sync_clr;
    logic          adv;
    logic          hit;

    always_comb begin
        state_nxt = state;
        go_init   = Addr15w && (D[1:0] == 2'b00);
        case (state)
            ST_INIT: if (Addr15w && (D[1:0] != 2'b00)) state_nxt = ST_RUN;
            ST_RUN:  if (Addr9w) state_nxt = ST_SYNC;
            ST_SYNC: if (enp) state_nxt = ST_RUN;
            default: state_nxt = ST_INIT;
        endcase
        // Stopping the prescalers overrides any pending re-phase.
        if (go_init) state_nxt = ST_INIT;
        hold_zero = go_init || (state == ST_INIT);
        sync_clr  = (state == ST_SYNC) && enp;
        adv       = (state == ST_RUN) && enp;
        hit       = audctl[0] ? (cnt15 == TC15) : (cnt64 == TC64);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_INIT;
            audctl   <= 8'h00;
            skctl    <= 2'b00;
            cnt64    <= '0;
            cnt15    <= '0;
            audClock <= 1'b0;
        end else begin
            state <= state_nxt;
            if (Addr8w)  audctl <= D;
            if (Addr15w) skctl  <= D[1:0];
            if (hold_zero || sync_clr) begin
                cnt64    <= '0;
                cnt15    <= '0;
                audClock <= 1'b0;
            end else if (adv) begin
                cnt64    <= (cnt64 == TC64) ? '0 : cnt64 + CW'(1);
                cnt15    <= (cnt15 == TC15) ? '0 : cnt15 + CW'(1);
                audClock <= hit;
            end
        end
    end

    assign poly9      = audctl[7];
    assign enFastClk1 = audctl[6];
    assign enFastClk3 = audctl[5];
    assign ch2Bits16  = audctl[4];
    assign ch4Bits16  = audctl[3];
    assign hpf1       = audctl[2];
    assign hpf2       = audctl[1];
    assign sel15k     = audctl[0];
    assign initMode   = (skctl == 2'b00);

endmodule

// File: tb/tb_aud_clk_sched.sv
// Bench for aud_clk_sched: directed scenarios plus randomized traffic against an
// enp-count reference model (prescaler phase = enp count since last clear, modulo).
module tb_aud_clk_sched;

    localparam int DIV64K = 28;
    localparam int DIV15K = 114;
    localparam int NWRAP  = DIV64K * DIV15K;

    logic       clk = 1'b0;
    logic       reset, enp, Addr8w, Addr9w, Addr15w;
    logic [7:0] D;
    logic       audClock, enFastClk1, enFastClk3, ch2Bits16, ch4Bits16;
    logic       hpf1, hpf2, poly9, sel15k, initMode;

    aud_clk_sched #(.DIV64K(DIV64K), .DIV15K(DIV15K), .CW(7)) dut (
        .clk(clk), .reset(reset), .enp(enp), .D(D),
        .Addr8w(Addr8w), .Addr9w(Addr9w), .Addr15w(Addr15w),
        .audClock(audClock), .enFastClk1(enFastClk1), .enFastClk3(enFastClk3),
        .ch2Bits16(ch2Bits16), .ch4Bits16(ch4Bits16), .hpf1(hpf1), .hpf2(hpf2),
        .poly9(poly9), .sel15k(sel15k), .initMode(initMode)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference model: mode 0 = stopped, 1 = running, 2 = re-phase pending
    logic [7:0] m_audctl;
    logic [1:0] m_skctl;
    int         m_mode;
    int         m_n;
    logic       m_aud;

    int enp_idx;
    int rises[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic go_init;
        if (reset) begin
            m_audctl = 8'h00; m_skctl = 2'b00; m_mode = 0; m_n = 0; m_aud = 1'b0;
        end else begin
            go_init = Addr15w && (D[1:0] == 2'b00);
            if (go_init || m_mode == 0) begin
                m_n = 0; m_aud = 1'b0;
            end else if (m_mode == 2) begin
                if (enp) begin m_n = 0; m_aud = 1'b0; end
            end else if (enp) begin
                m_aud = m_audctl[0] ? ((m_n % DIV15K) == DIV15K - 1)
                                    : ((m_n % DIV64K) == DIV64K - 1);
                m_n = (m_n + 1) % NWRAP;
            end
            if (go_init)                                    m_mode = 0;
            else if (m_mode == 0 && Addr15w)                m_mode = 1;
            else if (m_mode == 1 && Addr9w)                 m_mode = 2;
            else if (m_mode == 2 && enp)                    m_mode = 1;
            if (Addr8w)  m_audctl = D;
            if (Addr15w) m_skctl = D[1:0];
        end
    endtask

    task automatic cyc(input logic r, input logic e, input logic w8, input logic w9,
                       input logic w15, input logic [7:0] d);
        logic prev;
        reset = r; enp = e; Addr8w = w8; Addr9w = w9; Addr15w = w15; D = d;
        prev = audClock;
        @(posedge clk);
        model_edge();
        #1;
        check("audClock", audClock, m_aud);
        check("initMode", initMode, (m_skctl == 2'b00));
        check("audctl_out", {poly9, enFastClk1, enFastClk3, ch2Bits16, ch4Bits16,
                             hpf1, hpf2, sel15k}, m_audctl);
        if (e) begin
            enp_idx++;
            if (audClock && !prev) rises.push_back(enp_idx);
        end
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic enps(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (3) idle();
            cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        end
    endtask

    task automatic wr_audctl(input logic [7:0] d); cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, d); endtask
    task automatic wr_stimer();                    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); endtask
    task automatic wr_skctl(input logic [7:0] d);  cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, d); endtask

    task automatic restart_count();
        enp_idx = 0;
        rises.delete();
    endtask

    initial begin
        reset = 1'b1; enp = 1'b0; Addr8w = 1'b0; Addr9w = 1'b0; Addr15w = 1'b0; D = 8'h00;
        m_audctl = 8'h00; m_skctl = 2'b00; m_mode = 0; m_n = 0; m_aud = 1'b0;
        enp_idx = 0;

        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        check("rst_audClock", audClock, 1'b0);
        check("rst_initMode", initMode, 1'b1);
        check("rst_audctl", {poly9, enFastClk1, enFastClk3, ch2Bits16, ch4Bits16,
                             hpf1, hpf2, sel15k}, 8'h00);

        // 64 kHz base: first strobe on the 28th enp, then every 28
        wr_skctl(8'h03);
        wr_audctl(8'h00);
        restart_count();
        enps(60);
        check("s1_nrise", rises.size(), 2);
        check("s1_first", rises[0], 28);
        check("s1_second", rises[1], 56);

        // 15 kHz base, then switch back mid-period
        wr_audctl(8'h01);
        check("s2_sel15k", sel15k, 1'b1);
        restart_count();
        enps(250);
        check("s2_period", rises[1] - rises[0], DIV15K);
        wr_audctl(8'h00);
        enps(120);

        // STIMER re-phase at cnt64 = 13
        wr_stimer();
        enps(1);
        enps(13);
        wr_stimer();
        restart_count();
        enps(60);
        check("s3_after_sync", rises[0], 29);
        check("s3_period", rises[1] - rises[0], DIV64K);

        // STIMER coincident with enp: clear deferred to the following enp
        enps(5);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        wr_stimer();
        enps(40);

        // Stop and resume
        wr_skctl(8'h00);
        check("s4_initMode", initMode, 1'b1);
        restart_count();
        enps(200);
        check("s4_quiet", rises.size(), 0);
        wr_skctl(8'h03);
        check("s4_run", initMode, 1'b0);
        restart_count();
        enps(30);
        check("s4_resume", rises[0], 28);

        // Fast clock / join decode
        wr_audctl(8'h78);
        check("s5_fast_join", {enFastClk1, enFastClk3, ch2Bits16, ch4Bits16}, 4'hF);
        check("s5_others", {poly9, hpf1, hpf2, sel15k}, 4'h0);

        // STIMER with SKCTL 00 in the same cycle, then reset during SYNC
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        check("s6_init_wins", initMode, 1'b1);
        restart_count();
        enps(40);
        check("s6_quiet", rises.size(), 0);
        wr_skctl(8'h02);
        enps(27);
        wr_stimer();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("s6_rst_out", {audClock, initMode, poly9, enFastClk1, enFastClk3, ch2Bits16,
                             ch4Bits16, hpf1, hpf2, sel15k}, 10'b01_0000_0000);
        enps(30);
        check("s6_rst_quiet", audClock, 1'b0);

        // Randomized traffic
        wr_skctl(8'h01);
        for (int i = 0; i < 5000; i++) begin
            cyc($urandom_range(0, 399) == 0,
                $urandom_range(0, 2) == 0,
                $urandom_range(0, 39) == 0,
                $urandom_range(0, 49) == 0,
                $urandom_range(0, 79) == 0,
                8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
